// File: rtl/unpadding_pkg.sv
// Shared types and helpers for the unpadding stage (and the padding-side code).
// Positions are kept as a generic-width struct so both sides can share the border predicate.
package unpadding_pkg;

  localparam int POS_W = 16;

  // Position of one beat inside a padded frame: channel, column, row.
  typedef struct packed {
    logic [POS_W-1:0] c;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pad_pos_t;

  function automatic int padded_w(input int img, input int pad);
    return img + 2 * pad;
  endfunction

  function automatic int padded_h(input int img, input int pad);
    return img + 2 * pad;
  endfunction

  // True when the pixel at pos lies in the halo around the interior image.
  // The channel field does not affect the decision: all channels of a pixel share it.
  function automatic logic is_border(input pad_pos_t pos, input int img_w, input int img_h,
                                     input int pad_w, input int pad_h);
    int px;
    int py;
    px = int'(pos.x);
    py = int'(pos.y);
    return (px < pad_w) || (px > pad_w + img_w - 1) ||
           (py < pad_h) || (py > pad_h + img_h - 1);
  endfunction

endpackage

// File: rtl/unpadding_skid_buffer.sv
// Two-entry valid/ready buffer with a registered output.
// Ready depends only on the fill level, so there is no combinational path from i_ready to o_ready.
module unpadding_skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic w_push;
  logic w_pop;

  assign w_push  = i_valid && (r_count != 2'd2);
  assign w_pop   = (r_count != 2'd0) && i_ready;
  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];

  // Storage, pointers and fill level; a full buffer frees its slot only on the edge after a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/unpadding.sv
// Strips the halo from a padded, channel-interleaved pixel stream.
// Optional macro UNPADDING_PAD_CHECK_EN adds a sticky flag for nonzero border beats.
module unpadding
  import unpadding_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int IMG_WIDTH      = 4,
  parameter int IMG_HEIGHT     = 3,
  parameter int PADDING_WIDTH  = 2,
  parameter int PADDING_HEIGHT = 2,
  parameter int CHANNELS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  pad_error
);

  localparam int PAD_W = padded_w(IMG_WIDTH, PADDING_WIDTH);
  localparam int PAD_H = padded_h(IMG_HEIGHT, PADDING_HEIGHT);
  localparam int CW    = $clog2(CHANNELS) + 1;
  localparam int XW    = $clog2(PAD_W) + 1;
  localparam int YW    = $clog2(PAD_H) + 1;

  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
  localparam logic [XW-1:0] X_LAST = XW'(PAD_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(PAD_H - 1);

  logic [CW-1:0] r_count_c;
  logic [XW-1:0] r_count_x;
  logic [YW-1:0] r_count_y;

  pad_pos_t w_pos;
  logic     w_border;
  logic     w_buf_ready;
  logic     w_handshake;
  logic     w_buf_push;

  assign w_pos.c = POS_W'(r_count_c);
  assign w_pos.x = POS_W'(r_count_x);
  assign w_pos.y = POS_W'(r_count_y);

  assign w_border      = is_border(w_pos, IMG_WIDTH, IMG_HEIGHT, PADDING_WIDTH, PADDING_HEIGHT);
  // Border beats are always swallowed; interior beats wait for buffer space.
  assign data_in_ready = w_border ? 1'b1 : w_buf_ready;
  assign w_handshake   = data_in_valid && data_in_ready;
  assign w_buf_push    = data_in_valid && !w_border;

  // Position counters: channel fastest, then column, then row; advance on input handshakes only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count_c <= '0;
      r_count_x <= '0;
      r_count_y <= '0;
    end else if (w_handshake) begin
      if (r_count_c == C_LAST) begin
        r_count_c <= '0;
        if (r_count_x == X_LAST) begin
          r_count_x <= '0;
          if (r_count_y == Y_LAST) begin
            r_count_y <= '0;
          end else begin
            r_count_y <= r_count_y + YW'(1);
          end
        end else begin
          r_count_x <= r_count_x + XW'(1);
        end
      end else begin
        r_count_c <= r_count_c + CW'(1);
      end
    end
  end

  unpadding_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  (data_in),
    .i_valid (w_buf_push),
    .o_ready (w_buf_ready),
    .o_data  (data_out),
    .o_valid (data_out_valid),
    .i_ready (data_out_ready)
  );

`ifdef UNPADDING_PAD_CHECK_EN
  logic r_pad_error;

  // Sticky flag: any discarded border beat carrying nonzero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pad_error <= 1'b0;
    end else if (w_handshake && w_border && (data_in != '0)) begin
      r_pad_error <= 1'b1;
    end
  end

  assign pad_error = r_pad_error;
`else
  assign pad_error = 1'b0;
`endif

endmodule

// File: tb/tb_unpadding.sv
// Self-checking bench for unpadding: default geometry plus a zero-padding pass-through instance.
module tb_unpadding;

  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int IH    = 3;
  localparam int PW    = 2;
  localparam int PH    = 2;
  localparam int C     = 2;
  localparam int WP    = IW + 2 * PW;
  localparam int HP    = IH + 2 * PH;
  localparam int FRAME = WP * HP * C;
  localparam int NINT  = IW * IH * C;

`ifdef UNPADDING_PAD_CHECK_EN
  localparam logic PAD_EXP = 1'b1;
`else
  localparam logic PAD_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          pad_error;

  logic [DW-1:0] z_in;
  logic          z_in_valid;
  logic          z_in_ready;
  logic [DW-1:0] z_out;
  logic          z_out_valid;
  logic          z_out_ready;
  logic          z_pad_error;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] stim[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  unpadding #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
    .PADDING_WIDTH(PW), .PADDING_HEIGHT(PH), .CHANNELS(C)
  ) u_dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .pad_error(pad_error)
  );

  unpadding #(
    .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(3),
    .PADDING_WIDTH(0), .PADDING_HEIGHT(0), .CHANNELS(2)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .data_in(z_in), .data_in_valid(z_in_valid), .data_in_ready(z_in_ready),
    .data_out(z_out), .data_out_valid(z_out_valid), .data_out_ready(z_out_ready),
    .pad_error(z_pad_error)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: beat k of a padded stream is interior if its pixel lies inside the image.
  function automatic bit is_interior(input int k);
    int kk;
    int px;
    int x;
    int y;
    kk = k % FRAME;
    px = kk / C;
    x  = px % WP;
    y  = px / WP;
    return (x >= PW) && (x < PW + IW) && (y >= PH) && (y < PH + IH);
  endfunction

  // Streams stim[start..] into the DUT, scoring every output against the reference queue.
  task automatic run_stream(input int start, input int valid_pct, input int ready_pct,
                            output int ready_low, output int n_out);
    int sent;
    int cyc;
    bit stall;
    logic [DW-1:0] held;
    sent = start;
    cyc = 0;
    stall = 0;
    held = '0;
    ready_low = 0;
    n_out = 0;
    exp_q.delete();
    for (int i = start; i < stim.size(); i++) if (is_interior(i)) exp_q.push_back(stim[i]);
    while ((sent < stim.size() || exp_q.size() != 0) && cyc < 5000) begin
      data_in_valid  = (sent < stim.size()) && ($urandom_range(99) < valid_pct);
      data_in        = (sent < stim.size()) ? stim[sent] : '0;
      data_out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (stall) begin
        check("hold_valid", 32'(data_out_valid), 32'(1));
        check("hold_data", data_out, held);
      end
      if (!data_in_ready) ready_low++;
      if (data_in_valid && data_in_ready) sent++;
      if (data_out_valid && data_out_ready) begin
        n_out++;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL extra_output observed=%0h expected=none", data_out);
        end
        if (exp_q.size() != 0) check("out_data", data_out, exp_q.pop_front());
      end
      stall = data_out_valid && !data_out_ready;
      held  = data_out;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    assert (cyc < 5000) else begin
      failures++;
      $error("FAIL stream_timeout observed=%0d expected=<5000", cyc);
    end
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    @(negedge clk);
    check("drained_valid", 32'(data_out_valid), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rl;
    int nout;
    int sent;
    int first_int;
    logic [DW-1:0] zs[24];

    rst = 1'b1;
    data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    z_in = '0; z_in_valid = 1'b0; z_out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(data_out_valid), 32'(0));
    check("rst_data_out", data_out, 32'(0));
    check("rst_pad_error", 32'(pad_error), 32'(0));
    #10;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(data_in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Test 1: one frame of index data, full rate
    stim.delete();
    for (int i = 0; i < FRAME; i++) stim.push_back(32'(i));
    run_stream(0, 100, 100, rl, nout);
    check("t1_count", 32'(nout), 32'(NINT));
    check("t1_ready_never_low", 32'(rl), 32'(0));
    $display("t1 full-rate frame: outputs=%0d ready_low=%0d", nout, rl);

    // Test 2: same frame, random downstream backpressure
    run_stream(0, 100, 50, rl, nout);
    check("t2_count", 32'(nout), 32'(NINT));
    $display("t2 backpressure frame: outputs=%0d", nout);

    // Test 2b: random data, random valid and ready, two frames
    stim.delete();
    for (int i = 0; i < 2 * FRAME; i++) stim.push_back($urandom);
    run_stream(0, 60, 60, rl, nout);
    check("t2b_count", 32'(nout), 32'(2 * NINT));
    $display("t2b random traffic: outputs=%0d", nout);

    // Test 3: three back-to-back frames
    stim.delete();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < FRAME; i++) stim.push_back(32'(f * 1000 + i));
    run_stream(0, 100, 100, rl, nout);
    check("t3_count", 32'(nout), 32'(3 * NINT));
    check("t3_ready_never_low", 32'(rl), 32'(0));
    $display("t3 three frames: outputs=%0d", nout);

    // Test 4: reset mid-frame with the buffer full
    stim.delete();
    for (int i = 0; i < FRAME; i++) stim.push_back(32'(i));
    first_int = 0;
    while (!is_interior(first_int)) first_int++;
    data_out_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      data_in_valid = 1'b1;
      data_in = stim[sent];
      @(negedge clk);
      if (!data_in_ready) break;
      sent++;
      @(posedge clk);
      #1;
    end
    check("t4_stall_ready", 32'(data_in_ready), 32'(0));
    check("t4_stall_sent", 32'(sent), 32'(first_int + 2));
    check("t4_head_valid", 32'(data_out_valid), 32'(1));
    check("t4_head_data", data_out, stim[first_int]);
    data_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t4_rst_valid", 32'(data_out_valid), 32'(0));
    check("t4_rst_data", data_out, 32'(0));
    check("t4_rst_pad_error", 32'(pad_error), 32'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t4_release_ready", 32'(data_in_ready), 32'(1));
    @(posedge clk);
    #1;
    run_stream(0, 100, 100, rl, nout);
    check("t4_count", 32'(nout), 32'(NINT));
    $display("t4 reset mid-frame: sent_before=%0d outputs_after=%0d", sent, nout);

    // Test 5: nonzero first border beat, clean otherwise
    do_reset();
    stim.delete();
    for (int i = 0; i < FRAME; i++) stim.push_back(is_interior(i) ? 32'(i) : 32'(0));
    stim[0] = 32'h5;
    data_in_valid  = 1'b1;
    data_in        = stim[0];
    data_out_ready = 1'b1;
    @(negedge clk);
    check("t5_border_ready", 32'(data_in_ready), 32'(1));
    check("t5_pad_before", 32'(pad_error), 32'(0));
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    check("t5_pad_next", 32'(pad_error), 32'(PAD_EXP));
    run_stream(1, 100, 100, rl, nout);
    check("t5_count", 32'(nout), 32'(NINT));
    check("t5_pad_held", 32'(pad_error), 32'(PAD_EXP));
    $display("t5 pad check: pad_error=%0b outputs=%0d", pad_error, nout);

    // Test 6: zero-padding instance is a one-cycle pass-through at full rate
    for (int k = 0; k < 24; k++) zs[k] = $urandom;
    z_out_ready = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      z_in_valid = (k < 24);
      z_in       = (k < 24) ? zs[k] : '0;
      @(negedge clk);
      if (k < 24) check("t6_ready", 32'(z_in_ready), 32'(1));
      if (k > 0) begin
        check("t6_valid", 32'(z_out_valid), 32'(1));
        check("t6_data", z_out, zs[k-1]);
      end else begin
        check("t6_first_valid", 32'(z_out_valid), 32'(0));
      end
      check("t6_pad_error", 32'(z_pad_error), 32'(0));
      @(posedge clk);
      #1;
    end
    z_in_valid = 1'b0;
    @(negedge clk);
    check("t6_drained", 32'(z_out_valid), 32'(0));
    $display("t6 pass-through: 24 beats");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
